// File: rtl/oled_line_arbiter.sv
// -----------------------------------------------------------------------------
// oled_line_arbiter
//
// Shares one OLED text controller among NREQ line sources. Each source asks
// for a complete 16-character line on one of 4 rows. The arbiter grants
// round-robin and latches the granted row and text. It then streams 16
// character writes, issues one display update (never a clear), waits for the
// update to finish, and pulses ack to the served source.
//
// Optional build macro: OLED_LINE_ARB_DIFF_EN
//   When defined, a per-row shadow of the last completed line is kept.
//   Columns that already show the requested character are skipped, and a
//   line with no changes completes without any write or update.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   en                display available; gates new grants only
//   req[NREQ]         request levels, held until the matching ack
//   req_row[2*NREQ]   row per requester, slice [2i+1:2i]
//   req_text[128*NREQ] line per requester, slice [128i+127:128i], MS byte = col 0
//   ack[NREQ]         one-cycle completion pulse to the served requester
//   busy              high from grant through the ack cycle
//   grant_id          current / last granted requester
//   write_start       one-cycle character write strobe
//   write_ascii_data  character code
//   write_base_addr   {row, col, 3'b000}
//   write_ready       controller ready for a character write
//   update_start      one-cycle display update strobe
//   update_clear      always 0
//   update_ready      controller ready for an update
// -----------------------------------------------------------------------------
module oled_line_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NREQ-1:0]        req,
    input  logic [2*NREQ-1:0]      req_row,
    input  logic [128*NREQ-1:0]    req_text,
    output logic [NREQ-1:0]        ack,
    output logic                   busy,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   write_start,
    output logic [7:0]             write_ascii_data,
    output logic [8:0]             write_base_addr,
    input  logic                   write_ready,
    output logic                   update_start,
    output logic                   update_clear,
    input  logic                   update_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_START,
        S_WR_HOLD,
        S_WR_WAIT,
        S_UPD_START,
        S_UPD_HOLD,
        S_UPD_WAIT,
        S_ACK
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_grant_id;
    logic [3:0]         r_col;
    logic [1:0]         r_row;
    logic [127:0]       r_text;
    logic [NREQ-1:0]    r_ack;
    logic               r_busy;
    logic               r_write_start;
    logic [7:0]         r_wdata;
    logic [8:0]         r_waddr;
    logic               r_update_start;

    logic [IDX_W:0]     w_pick_res;
    logic               w_any;
    logic [IDX_W-1:0]   w_pick;
    logic               w_grant;
    logic [1:0]         w_sel_row;
    logic [127:0]       w_sel_text;
    logic [7:0]         w_char;
    logic [NREQ-1:0]    w_ack_onehot;

    // Round-robin search: scanning from the farthest candidate to the nearest
    // lets the requester closest after 'last' overwrite any earlier hit.
    function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDX_W-1:0] last);
        logic [IDX_W:0]  res;
        logic [NREQ-1:0] sh;
        int              idx;
        res = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            sh  = r >> idx;
            if (sh[0]) res = {1'b1, IDX_W'(idx)};
        end
        return res;
    endfunction

    assign w_pick_res = rr_pick(req, r_last);
    assign w_any      = w_pick_res[IDX_W];
    assign w_pick     = w_pick_res[IDX_W-1:0];
    assign w_grant    = (r_state == S_IDLE) && en && w_any;

    always_comb begin
        w_sel_row  = '0;
        w_sel_text = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == IDX_W'(i)) begin
                w_sel_row  = req_row[i*2 +: 2];
                w_sel_text = req_text[i*128 +: 128];
            end
        end
    end

    // Column 0 is the most significant byte, so column c sits at bit (15-c)*8.
    assign w_char       = r_text[{~r_col, 3'b000} +: 8];
    assign w_ack_onehot = NREQ'(1) << r_grant_id;

`ifdef OLED_LINE_ARB_DIFF_EN
    logic [127:0] r_shadow [4];
    logic [3:0]   r_row_vld;
    logic         r_dirty;
    logic [127:0] w_shadow_line;
    logic [7:0]   w_shadow_char;
    logic         w_skip;

    assign w_shadow_line = r_shadow[r_row];
    assign w_shadow_char = w_shadow_line[{~r_col, 3'b000} +: 8];
    assign w_skip        = r_row_vld[r_row] && (w_shadow_char == w_char);

    // The shadow holds what the panel shows once a line completes.
    always_ff @(posedge clk) begin
        if (r_state == S_ACK) r_shadow[r_row] <= r_text;
    end
`endif

    // Latched line: captured at grant, ignored changes on the inputs afterwards.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_row  <= w_sel_row;
            r_text <= w_sel_text;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_last         <= IDX_W'(NREQ - 1);
            r_grant_id     <= '0;
            r_col          <= '0;
            r_ack          <= '0;
            r_busy         <= 1'b0;
            r_write_start  <= 1'b0;
            r_wdata        <= '0;
            r_waddr        <= '0;
            r_update_start <= 1'b0;
`ifdef OLED_LINE_ARB_DIFF_EN
            r_row_vld      <= '0;
            r_dirty        <= 1'b0;
`endif
        end else begin
            r_write_start  <= 1'b0;
            r_update_start <= 1'b0;
            r_ack          <= '0;

            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_grant_id <= w_pick;
                        r_last     <= w_pick;
                        r_busy     <= 1'b1;
                        r_col      <= '0;
`ifdef OLED_LINE_ARB_DIFF_EN
                        r_dirty    <= 1'b0;
`endif
                        r_state    <= S_WR_START;
                    end
                end

                S_WR_START: begin
`ifdef OLED_LINE_ARB_DIFF_EN
                    // Unchanged characters cost one cycle each and need no
                    // controller handshake.
                    if (w_skip) begin
                        if (r_col == 4'd15) begin
                            if (r_dirty) begin
                                r_state <= S_UPD_START;
                            end else begin
                                r_ack   <= w_ack_onehot;
                                r_state <= S_ACK;
                            end
                        end else begin
                            r_col <= r_col + 4'd1;
                        end
                    end else
`endif
                    if (write_ready) begin
                        r_write_start <= 1'b1;
                        r_wdata       <= w_char;
                        r_waddr       <= {r_row, r_col, 3'b000};
`ifdef OLED_LINE_ARB_DIFF_EN
                        r_dirty       <= 1'b1;
`endif
                        r_state       <= S_WR_HOLD;
                    end
                end

                // Give the controller a cycle to drop write_ready.
                S_WR_HOLD: r_state <= S_WR_WAIT;

                S_WR_WAIT: begin
                    if (write_ready) begin
                        if (r_col == 4'd15) begin
                            r_state <= S_UPD_START;
                        end else begin
                            r_col   <= r_col + 4'd1;
                            r_state <= S_WR_START;
                        end
                    end
                end

                S_UPD_START: begin
                    if (update_ready) begin
                        r_update_start <= 1'b1;
                        r_state        <= S_UPD_HOLD;
                    end
                end

                S_UPD_HOLD: r_state <= S_UPD_WAIT;

                S_UPD_WAIT: begin
                    if (update_ready) begin
                        r_ack   <= w_ack_onehot;
                        r_state <= S_ACK;
                    end
                end

                S_ACK: begin
                    r_busy  <= 1'b0;
`ifdef OLED_LINE_ARB_DIFF_EN
                    r_row_vld[r_row] <= 1'b1;
`endif
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack              = r_ack;
    assign busy             = r_busy;
    assign grant_id         = r_grant_id;
    assign write_start      = r_write_start;
    assign write_ascii_data = r_wdata;
    assign write_base_addr  = r_waddr;
    assign update_start     = r_update_start;
    assign update_clear     = 1'b0;

endmodule

// File: doc/oled_line_arbiter.md
Name: oled_line_arbiter

Overview:
- Shares the single OLED text controller (character write + display update command interface) among NREQ requesters. Each requester asks for one full 16-character text line on one of the 4 rows.
- Arbitrates round-robin, latches the granted line, and issues 16 sequential character writes. It then issues one update (no clear), waits for completion, and acks the requester.
- Sits between status/text sources (firmware-version banner, run status, error text) and the OLED control module.

Parameters:
- NREQ, 2, number of requesters (1..4).
- IDX_W, 2, width of grant index; must satisfy 2**IDX_W >= NREQ.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- en  input  1  display available (OLED powered and initialised); no new grant while low
- req  input  NREQ  per-requester request level; held until matching ack
- req_row  input  2*NREQ  row for requester i at [2i+1:2i]; 0 = top row
- req_text  input  128*NREQ  line for requester i at [128i+127:128i]; the MS byte of each slice is column 0
- ack  output  NREQ  one-cycle pulse to the served requester on completion
- busy  output  1  high from grant until the ack cycle inclusive
- grant_id  output  IDX_W  index of the current/last granted requester
- write_start  output  1  one-cycle character write strobe
- write_ascii_data  output  8  character code
- write_base_addr  output  9  {row[1:0], col[3:0], 3'b000}
- write_ready  input  1  controller ready for a character write
- update_start  output  1  one-cycle display update strobe
- update_clear  output  1  held 0 by this block
- update_ready  input  1  controller ready for an update

Behaviour:
- Reset values: ack=0, busy=0, grant_id=0, write_start=0, update_start=0, update_clear=0, write_ascii_data=0, write_base_addr=0, state=IDLE, last-grant pointer=NREQ-1, so requester 0 wins first. Reset mid-transaction aborts at once; no ack is issued; requesters must keep req asserted and are re-served.
- IDLE: if en=1 and any req bit is set, pick the first requester set at or after last+1 (modulo NREQ). Latch its row and 128-bit text, set grant_id and last, busy<=1, col<=0, go to WR_START. Grant latency is 1 cycle from req sampled.
- WR_START: when write_ready=1, drive write_start=1 for exactly one cycle with the data/addr of column col, then go to WR_HOLD. Data and addr stay stable from this cycle until the next column's start.
- WR_HOLD: wait one cycle (controller ready deassert latency), then go to WR_WAIT.
- WR_WAIT: when write_ready=1: if col==15 go to UPD_START; otherwise col<=col+1 and go to WR_START. col is 4 bits and never wraps past 15 inside a transaction.
- UPD_START: when update_ready=1, pulse update_start for one cycle with update_clear=0, then go to UPD_HOLD (1 cycle), then UPD_WAIT.
- UPD_WAIT: when update_ready=1, go to ACK.
- ACK: ack[grant_id]=1 for one cycle, busy<=0, return to IDLE. The requester must drop req or present a new line; a req still high next cycle counts as a new request.
- req changes and latched-data changes during a grant are ignored; the latched copy is used.
- en falling mid-transaction does not abort; it only blocks the next grant.
- Simultaneous requests: strict round-robin, so no requester is served twice while another is waiting.
- Minimum transaction length: 16*3 + 3 + 1 cycles with a zero-wait controller.

Optional Feature:
- Macro OLED_LINE_ARB_DIFF_EN.
- Defined: keep a 4x128-bit shadow of the last line written per row, plus a per-row valid bit (cleared on reset).
  - When the row is valid, skip columns whose character equals the shadow; col advances 1 per cycle through skipped columns, with no write_start.
  - If all 16 columns match, skip the update and go directly to ACK.
  - The shadow is updated and the row marked valid on ACK.
- Undefined: no shadow; all 16 writes and 1 update are always issued.

Test Plan:
- Reset, then req=01, row0=2, text0="  AstroPix3 FW  " -> 16 write_start pulses, addrs 0x100,0x108..0x178, data 0x20,0x20,0x41..; one update_start with update_clear=0; ack=01 for 1 cycle.
- req=11 in the same cycle after reset -> requester 0 served first, then 1; grant_id 0 then 1; ack order 01 then 10.
- write_ready held low 10 cycles before column 5 -> write_start for col 5 delayed until ready=1; no duplicate or missing strobes; total 16.
- rst asserted after the 7th write_start -> all outputs return to reset values next cycle and there is no ack; with req held, a fresh transaction restarts at col 0.
- en=0 with req=01 -> no grant and busy=0; en->1 -> grant within 1 cycle.
- With OLED_LINE_ARB_DIFF_EN: the same line sent twice to row 1 -> the second request gives 0 write_start, 0 update_start, and ack within 18 cycles. Change one character at col 3 -> exactly 1 write_start (addr 0x098) plus 1 update_start.
